gf16_arith_unit: RTL and testbench
==================================

GF16_ARITH_UNIT -- requirements
Module: gf16_arith_unit

Interface
REQ-001 clock  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  one-cycle operation request, sampled on a rising clock edge.
REQ-004 op  input  2  00 = MUL (a*b mod f), 01 = RED (w mod f), 10 = INV (a^-1 mod f), 11 = reserved.
REQ-005 a  input  4  operand A, GF(2) polynomial, bit i = coefficient of x^i.
REQ-006 b  input  4  operand B; used by MUL only.
REQ-007 w  input  8  wide polynomial to reduce; used by RED only.
REQ-008 f  input  5  reduction polynomial of degree 4 (e.g. 5'b10011 = x^4+x+1).
REQ-009 result  output  4  registered 4-bit result.
REQ-010 prod  output  8  registered raw carry-less product a*b; MUL only, else 0.
REQ-011 busy  output  1  high while an INV is in progress.
REQ-012 done  output  1  one-cycle pulse when result is valid.
REQ-013 err  output  1  error flag; valid with done.

Function
REQ-014 All arithmetic SHALL be over GF(2): addition is XOR, with no carries.
REQ-015 Raw multiply SHALL be carry-less 4x4 to 7 bits, zero-extended to 8 bits (bit 7 = 0).
REQ-016 Reduction SHALL divide an 8-bit polynomial by f, clearing bits 7..4 from high to low, and yield the 4-bit remainder.
REQ-017 MUL and RED SHALL use one shared combinational reduction datapath.
REQ-018 Start accept rule: start is accepted only when busy = 0.
REQ-019 A start while busy = 1 SHALL be ignored, with no effect on state or outputs.
REQ-020 MUL, RED and reserved ops SHALL have latency 1: start sampled at edge k gives result/prod/err updated and done = 1 after edge k+1.
REQ-021 INV SHALL compute a^14 = a^2 * a^4 * a^8 mod f (the field inverse for irreducible f).
REQ-022 INV SHALL use a state machine with states IDLE, S1, S2, S3.
REQ-023 INV sequencing:
- start at edge k moves IDLE to S1.
- S1, S2 and S3 each take one cycle: square the running power, then multiply into the accumulator, both mod f.
- S3 returns to IDLE and loads result.
REQ-024 INV timing: busy = 1 after edges k+1..k+3; done = 1 and result valid after edge k+4; busy = 0 at that point.
REQ-025 done SHALL be high exactly one cycle per accepted operation, and otherwise low.
REQ-026 result, prod and err SHALL hold their values until the next accepted operation completes.
REQ-027 Operands a, b, w, f SHALL be captured at start; later changes SHALL NOT affect an in-flight INV.
REQ-028 INV with a = 0 SHALL produce result = 0 and err = 1, with normal 4-cycle latency.
REQ-029 f[4] = 0 (not degree 4) SHALL produce result = 0 and err = 1 for any op, with normal latency.
REQ-030 op = 11 SHALL produce result = 0 and err = 1.
REQ-031 All other completions SHALL produce err = 0.
REQ-032 Irreducibility of f SHALL NOT be checked; a reducible f gives a^14 mod f with err = 0.
REQ-033 prod SHALL be 0 on every completion other than MUL.

Reset
REQ-034 reset = 1 SHALL immediately force: state to IDLE; result = 0, prod = 0, busy = 0, done = 0, err = 0.
REQ-035 Reset mid-INV SHALL abort the operation with no done pulse.
REQ-036 After reset deasserts, the first rising edge with start = 1 SHALL be accepted.

Verification
REQ-037 Bench SHALL cover: f = 10011, op = MUL, a = 1001, b = 0010 -> prod = 00010010, result = 0001, done after 1 cycle, err = 0.
REQ-038 Bench SHALL cover: f = 10011, op = MUL, a = 1111, b = 1111 -> prod = 01010101, result = 1010.
REQ-039 Bench SHALL cover: f = 10011, op = RED, w = 00010010 -> result = 0001.
REQ-040 Bench SHALL cover: f = 10011, op = RED, w = 00000100 -> result = 0100.
REQ-041 Bench SHALL cover: f = 10011, op = INV, a = 1001 -> busy for 3 cycles, result = 0010 with done after edge k+4.
REQ-042 Bench SHALL cover: f = 10011, op = INV, a = 0001 -> result = 0001.
REQ-043 Bench SHALL cover: f = 10011, op = INV, a = 0000 -> result = 0000, err = 1.
REQ-044 Bench SHALL cover: start an INV, assert reset after edge k+2 -> all outputs 0 immediately, no done, next start accepted normally.
REQ-045 Bench SHALL cover: a second start during INV busy -> ignored; only one done, carrying the first operation's result.
REQ-046 Bench SHALL cover: sweep all a = 1..15 with f = 10011 -> MUL(a, INV(a)) gives result = 0001.

Source files
------------

// File: rtl/gf16_arith_unit.sv
// GF(16) arithmetic unit: carry-less multiply, reduction modulo a degree-4 polynomial,
// and a three-step square-and-multiply inverse (a^14) sequenced by a small FSM.
module gf16_arith_unit (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [1:0] op_i,
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [7:0] w_i,
    input  logic [4:0] f_i,
    output logic [3:0] result_o,
    output logic [7:0] prod_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_RED = 2'b01;
    localparam logic [1:0] OP_INV = 2'b10;

    typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_S1 = 2'b01, ST_S2 = 2'b10, ST_S3 = 2'b11} state_t;

    function automatic logic [7:0] gf_clmul(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 4; i++) begin
            acc = acc ^ (({4'h0, x} << i) & {8{y[i]}});
        end
        return acc;
    endfunction

    // Long division by f: each set bit 7..4 is cancelled by a shifted copy of f.
    function automatic logic [3:0] gf_reduce(input logic [7:0] v, input logic [4:0] f);
        logic [7:0] r;
        r = v;
        for (int i = 7; i >= 4; i--) begin
            r = r ^ (({3'b000, f} << (i - 4)) & {8{r[i]}});
        end
        return r[3:0];
    endfunction

    state_t     state_q, state_d;
    logic       req_q, req_d;
    logic [1:0] op_q, op_d;
    logic [3:0] a_q, a_d, b_q, b_d;
    logic [7:0] w_q, w_d;
    logic [4:0] f_q, f_d;
    logic [3:0] pow_q, pow_d, acc_q, acc_d;
    logic [3:0] result_q, result_d;
    logic [7:0] prod_q, prod_d;
    logic       busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic       accept_s;
    logic [7:0] raw_prod_s, red_in_s;
    logic [3:0] red_out_s, sq_s, step_s;

    // Shared MUL/RED reduction path, plus the INV square-then-multiply step.
    always_comb begin
        raw_prod_s = gf_clmul(a_q, b_q);
        red_in_s   = (op_q == OP_RED) ? w_q : raw_prod_s;
        red_out_s  = gf_reduce(red_in_s, f_q);
        sq_s       = gf_reduce(gf_clmul(pow_q, pow_q), f_q);
        step_s     = gf_reduce(gf_clmul(acc_q, sq_s), f_q);
    end

    // Next-state logic: operand capture, FSM sequencing and completion outputs.
    always_comb begin
        state_d  = state_q;
        pow_d    = pow_q;
        acc_d    = acc_q;
        result_d = result_q;
        prod_d   = prod_q;
        err_d    = err_q;
        done_d   = 1'b0;
        // A captured INV that has not yet entered S1 also blocks new starts.
        accept_s = start_i && (state_q == ST_IDLE) && !(req_q && (op_q == OP_INV));
        req_d    = accept_s;
        if (accept_s) begin
            op_d = op_i;
            a_d  = a_i;
            b_d  = b_i;
            w_d  = w_i;
            f_d  = f_i;
        end else begin
            op_d = op_q;
            a_d  = a_q;
            b_d  = b_q;
            w_d  = w_q;
            f_d  = f_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_q && (op_q == OP_INV)) begin
                    state_d = ST_S1;
                    pow_d   = a_q;
                    acc_d   = 4'h1;
                end else if (req_q) begin
                    done_d = 1'b1;
                    prod_d = (op_q == OP_MUL) ? raw_prod_s : 8'h00;
                    if (!f_q[4] || (op_q == 2'b11)) begin
                        result_d = 4'h0;
                        err_d    = 1'b1;
                    end else begin
                        result_d = red_out_s;
                        err_d    = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_S1: begin
                pow_d   = sq_s;
                acc_d   = step_s;
                state_d = ST_S2;
            end
            ST_S2: begin
                pow_d   = sq_s;
                acc_d   = step_s;
                state_d = ST_S3;
            end
            ST_S3: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                prod_d  = 8'h00;
                if (!f_q[4] || (a_q == 4'h0)) begin
                    result_d = 4'h0;
                    err_d    = 1'b1;
                end else begin
                    result_d = step_s;
                    err_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            op_q     <= 2'b00;
            a_q      <= 4'h0;
            b_q      <= 4'h0;
            w_q      <= 8'h00;
            f_q      <= 5'h00;
            pow_q    <= 4'h0;
            acc_q    <= 4'h0;
            result_q <= 4'h0;
            prod_q   <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            w_q      <= w_d;
            f_q      <= f_d;
            pow_q    <= pow_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            prod_q   <= prod_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign result_o = result_q;
    assign prod_o   = prod_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_gf16_arith_unit.sv
// Self-checking bench for gf16_arith_unit: directed cases, reset/busy corner cases and
// randomized operations against a polynomial reference model.
module tb_gf16_arith_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [3:0] a = 4'h0, b = 4'h0;
    logic [7:0] w = 8'h00;
    logic [4:0] f = 5'h13;
    logic [3:0] result;
    logic [7:0] prod;
    logic       busy, done, err;

    int    checks = 0;
    int    errors = 0;
    string ctx = "init";

    gf16_arith_unit dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .w_i(w), .f_i(f), .result_o(result), .prod_o(prod), .busy_o(busy),
        .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] m_clmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 8; i++) if (y[i]) r = r ^ (x << i);
        return r;
    endfunction

    // Remainder: the unique r of degree < 4 such that w ^ r is a multiple of f.
    function automatic logic [3:0] m_red(input logic [7:0] wv, input logic [4:0] fv);
        logic [7:0] t;
        for (int q = 0; q < 16; q++) begin
            t = m_clmul(8'(q), {3'b000, fv}) ^ wv;
            if (t[7:4] == 4'h0) return t[3:0];
        end
        return 4'h0;
    endfunction

    // Shift-and-add multiply with reduction after every doubling.
    function automatic logic [3:0] m_gfmul(input logic [3:0] x, input logic [3:0] y, input logic [4:0] fv);
        logic [4:0] s = {1'b0, x};
        logic [3:0] p = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (y[i]) p = p ^ s[3:0];
            s = s << 1;
            if (s[4]) s = s ^ fv;
        end
        return p;
    endfunction

    function automatic logic [3:0] m_pow14(input logic [3:0] x, input logic [4:0] fv);
        logic [3:0] r = 4'h1;
        for (int i = 0; i < 14; i++) r = m_gfmul(r, x, fv);
        return r;
    endfunction

    task automatic m_expect(input logic [1:0] o, input logic [3:0] av, input logic [3:0] bv,
                            input logic [7:0] wv, input logic [4:0] fv,
                            output logic [3:0] er, output logic [7:0] ep, output logic ee);
        ep = (o == 2'b00) ? m_clmul({4'h0, av}, {4'h0, bv}) : 8'h00;
        er = 4'h0;
        ee = 1'b1;
        if (fv[4] && o != 2'b11) begin
            ee = 1'b0;
            if (o == 2'b00) er = m_gfmul(av, bv, fv);
            else if (o == 2'b01) er = m_red(wv, fv);
            else if (av == 4'h0) ee = 1'b1;
            else er = m_pow14(av, fv);
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed=%h expected=%h", ctx, tag, obs, exp);
        end
    endtask

    // Drives one start pulse sampled at edge k; returns #1 after edge k with operands scrambled.
    task automatic drive_start(input logic [1:0] o, input logic [3:0] av, input logic [3:0] bv,
                               input logic [7:0] wv, input logic [4:0] fv);
        @(negedge clk);
        op = o; a = av; b = bv; w = wv; f = fv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 4'($urandom); b = 4'($urandom); w = 8'($urandom); f = 5'($urandom);
        op = 2'($urandom);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [3:0] av, input logic [3:0] bv,
                          input logic [7:0] wv, input logic [4:0] fv, output logic [3:0] got);
        logic [3:0] er;
        logic [7:0] ep;
        logic       ee;
        int         lat;
        m_expect(o, av, bv, wv, fv, er, ep, ee);
        lat = (o == 2'b10) ? 4 : 1;
        drive_start(o, av, bv, wv, fv);
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk);
            #1;
            if (c < lat) begin
                chk("early_done", 8'(done), 8'h00);
                chk("busy", 8'(busy), 8'h01);
            end else begin
                chk("done", 8'(done), 8'h01);
                chk("busy_end", 8'(busy), 8'h00);
                chk("result", 8'(result), 8'(er));
                chk("prod", prod, ep);
                chk("err", 8'(err), 8'(ee));
            end
        end
        got = result;
        @(posedge clk);
        #1;
        chk("done_pulse", 8'(done), 8'h00);
        chk("hold_result", 8'(result), 8'(er));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] got, inv;
        logic [1:0] ro;
        logic [4:0] rf;

        ctx = "reset";
        #2 rst = 1'b1;
        #1;
        chk("result", 8'(result), 8'h00);
        chk("prod", prod, 8'h00);
        chk("busy", 8'(busy), 8'h00);
        chk("done", 8'(done), 8'h00);
        chk("err", 8'(err), 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        ctx = "mul_9x2";
        run_op(2'b00, 4'h9, 4'h2, 8'h00, 5'h13, got);
        chk("const_prod", prod, 8'h12);
        chk("const_result", 8'(result), 8'h01);

        ctx = "mul_fxf";
        run_op(2'b00, 4'hF, 4'hF, 8'h00, 5'h13, got);
        chk("const_prod", prod, 8'h55);
        chk("const_result", 8'(result), 8'h0A);

        ctx = "red_12";
        run_op(2'b01, 4'h0, 4'h0, 8'h12, 5'h13, got);
        chk("const_result", 8'(result), 8'h01);

        ctx = "red_04";
        run_op(2'b01, 4'h0, 4'h0, 8'h04, 5'h13, got);
        chk("const_result", 8'(result), 8'h04);

        ctx = "inv_9";
        run_op(2'b10, 4'h9, 4'h0, 8'h00, 5'h13, got);
        chk("const_result", 8'(result), 8'h02);

        ctx = "inv_1";
        run_op(2'b10, 4'h1, 4'h0, 8'h00, 5'h13, got);
        chk("const_result", 8'(result), 8'h01);

        ctx = "inv_0";
        run_op(2'b10, 4'h0, 4'h0, 8'h00, 5'h13, got);
        chk("const_err", 8'(err), 8'h01);

        ctx = "reserved";
        run_op(2'b11, 4'h7, 4'h3, 8'hA5, 5'h13, got);
        ctx = "bad_f_red";
        run_op(2'b01, 4'h0, 4'h0, 8'hF3, 5'h0B, got);
        ctx = "bad_f_inv";
        run_op(2'b10, 4'h6, 4'h0, 8'h00, 5'h03, got);
        ctx = "reducible_inv";
        run_op(2'b10, 4'h7, 4'h0, 8'h00, 5'h11, got);

        // Abort an INV with reset after edge k+2; outputs must clear at once.
        ctx = "reset_mid_inv";
        run_op(2'b00, 4'hF, 4'hF, 8'h00, 5'h13, got);
        drive_start(2'b10, 4'h9, 4'h0, 8'h00, 5'h13);
        @(posedge clk);
        #1;
        chk("busy_k1", 8'(busy), 8'h01);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("result", 8'(result), 8'h00);
        chk("prod", prod, 8'h00);
        chk("busy", 8'(busy), 8'h00);
        chk("done", 8'(done), 8'h00);
        chk("err", 8'(err), 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk("no_done", 8'(done), 8'h00);
        end
        ctx = "after_reset";
        run_op(2'b10, 4'h9, 4'h0, 8'h00, 5'h13, got);

        // A second start while busy must be ignored.
        ctx = "start_while_busy";
        drive_start(2'b10, 4'h9, 4'h0, 8'h00, 5'h13);
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            #1;
            chk("done", 8'(done), (c == 4) ? 8'h01 : 8'h00);
            if (c == 1) begin
                op = 2'b00; a = 4'hF; b = 4'hF; f = 5'h13; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (c == 4) begin
                chk("result", 8'(result), 8'h02);
                chk("prod", prod, 8'h00);
                chk("err", 8'(err), 8'h00);
            end
        end

        // Inverse sweep: a * INV(a) must be 1 for every nonzero a.
        for (int i = 1; i < 16; i++) begin
            ctx = $sformatf("sweep_inv_%0d", i);
            run_op(2'b10, 4'(i), 4'h0, 8'h00, 5'h13, inv);
            ctx = $sformatf("sweep_mul_%0d", i);
            run_op(2'b00, 4'(i), inv, 8'h00, 5'h13, got);
            chk("a_times_inv", 8'(got), 8'h01);
        end

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            rf = ($urandom_range(0, 7) == 0) ? {1'b0, 4'($urandom)} : {1'b1, 4'($urandom)};
            ctx = $sformatf("rand_%0d_op%0d_f%h", i, ro, rf);
            run_op(ro, 4'($urandom), 4'($urandom), 8'($urandom), rf, got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
